// File: rtl/biquad_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : biquad_sequencer                                           |
// | Purpose  : Direct-Form-II biquad control FSM and shared MAC.          |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module biquad_sequencer #(
    parameter int N = 16,
    parameter int F = 14,
    parameter int G = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sample_tick,
    input  logic [N-1:0] x_in,
    input  logic [N-1:0] muxS,
    input  logic [N-1:0] muxC,
    input  logic [N-1:0] muxZ,
    output logic [2:0]   controlS,
    output logic [1:0]   controlC,
    output logic [1:0]   controlZ,
    output logic [N-1:0] Uk,
    output logic [N-1:0] fk,
    output logic [N-1:0] fk1,
    output logic [N-1:0] fk2,
    output logic [N-1:0] yk,
    output logic         y_valid,
    output logic         busy,
    output logic         overrun
);

    localparam int ACCW = N + G;

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_LOAD = 3'd1;
    localparam logic [2:0] c_A1   = 3'd2;
    localparam logic [2:0] c_A2   = 3'd3;
    localparam logic [2:0] c_B0   = 3'd4;
    localparam logic [2:0] c_B1   = 3'd5;
    localparam logic [2:0] c_B2   = 3'd6;
    localparam logic [2:0] c_DONE = 3'd7;

    localparam logic signed [ACCW-1:0] c_SMAX = ACCW'((1 << (N - 1)) - 1);
    localparam logic signed [ACCW-1:0] c_SMIN = ~c_SMAX;

    logic [2:0]              r_state;
    logic [2:0]              w_next;
    logic signed [ACCW-1:0]  r_acc;
    logic signed [2*N-1:0]   w_prod;
    logic signed [2*N-1:0]   w_shift;
    logic signed [ACCW-1:0]  w_scaled;
    logic signed [ACCW-1:0]  w_sum;
    logic [2:0]              w_sel_s;
    logic [1:0]              w_sel_c;
    logic [1:0]              w_sel_z;
    logic                    w_valid;
    logic                    w_busy;

    function automatic logic [N-1:0] sat(input logic signed [ACCW-1:0] v);
        if (v > c_SMAX)
            return c_SMAX[N-1:0];
        else if (v < c_SMIN)
            return c_SMIN[N-1:0];
        else
            return v[N-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (!reset)
            r_state <= c_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  w_next = sample_tick ? c_LOAD : c_IDLE;
            c_LOAD:  w_next = c_A1;
            c_A1:    w_next = c_A2;
            c_A2:    w_next = c_B0;
            c_B0:    w_next = c_B1;
            c_B1:    w_next = c_B2;
            c_B2:    w_next = c_DONE;
            default: w_next = c_IDLE;
        endcase
    end

    // Decode the next state so the registered selects line up with r_state.
    always_comb begin
        w_sel_s = 3'd0;
        w_sel_c = 2'd0;
        w_sel_z = 2'd0;
        w_valid = (w_next == c_DONE);
        w_busy  = (w_next != c_IDLE);
        case (w_next)
            c_LOAD: w_sel_z = 2'd1;
            c_A1:   begin w_sel_s = 3'd1; w_sel_c = 2'd1; end
            c_A2:   begin w_sel_s = 3'd2; w_sel_c = 2'd2; end
            c_B0:   begin w_sel_s = 3'd3; w_sel_c = 2'd3; end
            c_B1:   begin w_sel_s = 3'd4; w_sel_c = 2'd1; end
            c_B2:   begin w_sel_s = 3'd5; w_sel_c = 2'd2; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            controlS <= 3'd0;
            controlC <= 2'd0;
            controlZ <= 2'd0;
            y_valid  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            controlS <= w_sel_s;
            controlC <= w_sel_c;
            controlZ <= w_sel_z;
            y_valid  <= w_valid;
            busy     <= w_busy;
        end
    end

    // Shared MAC: floor-scaled product folded into the guard-bit accumulator.
    assign w_prod   = $signed(muxS) * $signed(muxC);
    assign w_shift  = w_prod >>> F;
    assign w_scaled = w_shift[ACCW-1:0];
    assign w_sum    = r_acc + w_scaled;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_acc   <= '0;
            Uk      <= '0;
            fk      <= '0;
            fk1     <= '0;
            fk2     <= '0;
            yk      <= '0;
            overrun <= 1'b0;
        end else begin
            if (sample_tick && (r_state != c_IDLE))
                overrun <= 1'b1;
            case (r_state)
                c_IDLE: if (sample_tick) Uk <= x_in;
                c_LOAD: r_acc <= {{G{muxZ[N-1]}}, muxZ};
                c_A1:   r_acc <= w_sum;
                c_A2: begin
                    r_acc <= w_sum;
                    fk    <= sat(w_sum);
                end
                c_B0:   r_acc <= w_scaled;
                c_B1:   r_acc <= w_sum;
                c_B2: begin
                    yk  <= sat(w_sum);
                    fk2 <= fk1;
                    fk1 <= fk;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_biquad_sequencer.sv
`default_nettype none
// Directed bench for biquad_sequencer with a behavioural mux and
// a floor/saturate arithmetic model of the DF-II recursion.
module tb_biquad_sequencer;

    localparam int N = 16;
    localparam int F = 14;

    localparam logic signed [N-1:0] C_A1 = 16'sd16957;
    localparam logic signed [N-1:0] C_A2 = -16'sd6021;
    localparam logic signed [N-1:0] C_B0 = 16'sd1362;
    localparam logic signed [N-1:0] C_B1 = 16'sd2724;
    localparam logic signed [N-1:0] C_B2 = 16'sd1362;

    logic         clk;
    logic         reset;
    logic         sample_tick;
    logic [N-1:0] x_in;
    logic [N-1:0] muxS, muxC, muxZ;
    logic [2:0]   controlS;
    logic [1:0]   controlC, controlZ;
    logic [N-1:0] Uk, fk, fk1, fk2, yk;
    logic         y_valid, busy, overrun;

    int n_tests = 0;
    int n_fail  = 0;

    longint m_uk, m_fk, m_fk1, m_fk2, m_yk;

    biquad_sequencer #(.N(N), .F(F), .G(2)) dut (
        .clk(clk), .reset(reset), .sample_tick(sample_tick), .x_in(x_in),
        .muxS(muxS), .muxC(muxC), .muxZ(muxZ),
        .controlS(controlS), .controlC(controlC), .controlZ(controlZ),
        .Uk(Uk), .fk(fk), .fk1(fk1), .fk2(fk2), .yk(yk),
        .y_valid(y_valid), .busy(busy), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Combinational coefficient/operand mux.
    always_comb begin
        muxS = '0;
        muxC = '0;
        muxZ = '0;
        case (controlS)
            3'd1: muxS = C_A1;
            3'd2: muxS = C_A2;
            3'd3: muxS = C_B0;
            3'd4: muxS = C_B1;
            3'd5: muxS = C_B2;
            default: muxS = '0;
        endcase
        case (controlC)
            2'd1: muxC = fk1;
            2'd2: muxC = fk2;
            2'd3: muxC = fk;
            default: muxC = '0;
        endcase
        case (controlZ)
            2'd1: muxZ = Uk;
            2'd2: muxZ = yk;
            default: muxZ = '0;
        endcase
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint wrapacc(input longint v);
        logic signed [N+1:0] t;
        t = v[N+1:0];
        return longint'(t);
    endfunction

    function automatic longint satn(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic longint sc(input logic signed [N-1:0] c, input longint s);
        longint p;
        p = longint'(c) * s;
        return wrapacc(p >>> F);
    endfunction

    task automatic model_reset();
        m_uk = 0; m_fk = 0; m_fk1 = 0; m_fk2 = 0; m_yk = 0;
    endtask

    task automatic model_step(input logic [N-1:0] x);
        longint acc;
        m_uk = longint'($signed(x));
        acc  = wrapacc(m_uk + sc(C_A1, m_fk1));
        acc  = wrapacc(acc + sc(C_A2, m_fk2));
        m_fk = satn(acc);
        acc  = sc(C_B0, m_fk);
        acc  = wrapacc(acc + sc(C_B1, m_fk1));
        m_yk = satn(wrapacc(acc + sc(C_B2, m_fk2)));
        m_fk2 = m_fk1;
        m_fk1 = m_fk;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_uk"},  longint'($signed(Uk)),  m_uk);
        chk({tag, "_fk"},  longint'($signed(fk)),  m_fk);
        chk({tag, "_fk1"}, longint'($signed(fk1)), m_fk1);
        chk({tag, "_fk2"}, longint'($signed(fk2)), m_fk2);
        chk({tag, "_yk"},  longint'($signed(yk)),  m_yk);
    endtask

    // Tick at a negedge, walk to DONE (7 cycles later), then pad to the gap.
    task automatic run_sample(input logic [N-1:0] x, input int gap, input bit log_sel);
        logic [6:0] exp_sel [1:7];
        logic [6:0] got_sel [1:7];
        int nvalid;
        exp_sel[1] = {3'd0, 2'd0, 2'd1};
        exp_sel[2] = {3'd1, 2'd1, 2'd0};
        exp_sel[3] = {3'd2, 2'd2, 2'd0};
        exp_sel[4] = {3'd3, 2'd3, 2'd0};
        exp_sel[5] = {3'd4, 2'd1, 2'd0};
        exp_sel[6] = {3'd5, 2'd2, 2'd0};
        exp_sel[7] = {3'd0, 2'd0, 2'd0};
        nvalid = 0;
        @(negedge clk);
        sample_tick = 1'b1;
        x_in = x;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            sample_tick = 1'b0;
            if (y_valid) nvalid++;
            got_sel[i] = {controlS, controlC, controlZ};
            if (i == 1) chk("busy_load", longint'(busy), 1);
        end
        chk("y_valid_t7", longint'(y_valid), 1);
        chk("y_valid_count", longint'(nvalid), 1);
        model_step(x);
        chk_state("sample");
        if (log_sel) begin
            for (int i = 1; i <= 7; i++)
                chk($sformatf("sel_cycle%0d", i), longint'(got_sel[i]), longint'(exp_sel[i]));
        end
        repeat (gap - 8) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        reset = 1'b0;
        sample_tick = 1'b0;
        x_in = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_overrun", longint'(overrun), 0);
        chk("rst_yvalid", longint'(y_valid), 0);
        chk("rst_sel", longint'({controlS, controlC, controlZ}), 0);
        chk_state("rst");
        reset = 1'b1;

        // Impulse response: 1.0 then zeros.
        run_sample(16'd16384, 10, 1'b1);
        chk("imp0_fk", longint'($signed(fk)), 16384);
        chk("imp0_yk", longint'($signed(yk)), 1362);
        run_sample(16'd0, 10, 1'b0);
        chk("imp1_fk", longint'($signed(fk)), 16957);
        chk("imp1_yk", longint'($signed(yk)), 4133);
        repeat (4) run_sample(16'd0, 10, 1'b0);

        // Random samples, then reset asserted mid-B0.
        repeat (3) run_sample(N'($urandom), 10, 1'b0);
        @(negedge clk);
        sample_tick = 1'b1;
        x_in = 16'd5000;
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        chk("midrst_busy", longint'(busy), 0);
        chk("midrst_yvalid", longint'(y_valid), 0);
        chk("midrst_sel", longint'({controlS, controlC, controlZ}), 0);
        chk_state("midrst");
        reset = 1'b1;
        run_sample(16'd8192, 10, 1'b0);
        chk("postrst_yk", longint'($signed(yk)), 681);

        // Overrun: tick at t+3 ignored, tick in DONE flagged, tick at t+8 accepted.
        pulse_reset();
        @(negedge clk);
        sample_tick = 1'b1;
        x_in = 16'd100;
        @(negedge clk);
        sample_tick = 1'b0;
        chk("ovr_clear", longint'(overrun), 0);
        @(negedge clk);
        @(negedge clk);
        sample_tick = 1'b1;
        x_in = 16'd200;
        @(negedge clk);
        sample_tick = 1'b0;
        chk("ovr_set", longint'(overrun), 1);
        chk("ovr_uk", longint'($signed(Uk)), 100);
        repeat (3) @(negedge clk);
        model_step(16'd100);
        chk("ovr_yk", longint'($signed(yk)), m_yk);
        sample_tick = 1'b1;
        x_in = 16'd300;
        @(negedge clk);
        chk("done_tick_busy", longint'(busy), 0);
        chk("done_tick_uk", longint'($signed(Uk)), 100);
        chk("done_tick_ovr", longint'(overrun), 1);
        x_in = 16'd400;
        @(negedge clk);
        sample_tick = 1'b0;
        chk("t8_busy", longint'(busy), 1);
        chk("t8_uk", longint'($signed(Uk)), 400);
        repeat (6) @(negedge clk);
        model_step(16'd400);
        chk("t8_yvalid", longint'(y_valid), 1);
        chk_state("t8");
        chk("ovr_sticky", longint'(overrun), 1);

        // Saturation at both rails.
        pulse_reset();
        repeat (20) run_sample(16'h7FFF, 10, 1'b0);
        chk("satp_fk", longint'($signed(fk)), 32767);
        chk("satp_yk_sign", longint'(yk[N-1]), 0);
        pulse_reset();
        repeat (20) run_sample(16'h8000, 10, 1'b0);
        chk("satn_fk", longint'($signed(fk)), -32768);
        chk("satn_yk_sign", longint'(yk[N-1]), 1);

        // Back-to-back at maximum throughput.
        pulse_reset();
        repeat (50) run_sample(N'($urandom), 8, 1'b0);
        chk("b2b_overrun", longint'(overrun), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
